// File: rtl/mem_port_arbiter.sv
// Arbitrates N requesters onto the single cache/memory_system port.
// Round-robin or fixed priority, flush squash of reads, completion timeout.
module mem_port_arbiter #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned RR_EN = 1,
    parameter int unsigned TMO   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flsh,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH-1:0]    rd_wrt,
    input  logic [N_CH*AW-1:0] addr_in,
    input  logic [N_CH*DW-1:0] wdata_in,
    output logic [N_CH-1:0]    grnt,
    output logic [N_CH-1:0]    ch_done,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      addr_ca,
    output logic [DW-1:0]      data_ca_in,
    output logic               rd_wrt_ca,
    output logic               enable,
    input  logic               idle,
    input  logic               done,
    input  logic [DW-1:0]      data_ca_out,
    output logic               tmo_err
);

    localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW = $clog2(TMO);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [N_CH-1:0]  grnt_q, grnt_d;
    logic             enable_q, enable_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             squash_q, squash_d;
    logic             tmo_err_q, tmo_err_d;

    logic             sel_vld;
    logic [PW-1:0]    sel_idx;
    logic [PW:0]      cand;
    logic [PW-1:0]    ptr_nxt;
    logic             flush_rd;
    logic [N_CH-1:0]  ch_done_c;

    // Winner search: cyclic scan from rr_ptr, or plain lowest index in fixed mode.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (RR_EN != 0) begin
                cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
                if (cand >= (PW+1)'(N_CH)) begin
                    cand = cand - (PW+1)'(N_CH);
                end
            end else begin
                cand = (PW+1)'(k);
            end
            if (!sel_vld && req[cand[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[PW-1:0];
            end
        end
    end

    // Pointer wraps explicitly so non-power-of-2 channel counts stay legal.
    assign ptr_nxt  = (win_q == PW'(N_CH - 1)) ? '0 : win_q + PW'(1);
    assign flush_rd = flsh && !rw_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        grnt_d    = grnt_q;
        enable_d  = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        cnt_d     = cnt_q;
        squash_d  = squash_q;
        tmo_err_d = tmo_err_q;

        case (state_q)
            S_IDLE: begin
                grnt_d   = '0;
                squash_d = 1'b0;
                if (idle && sel_vld && !flsh) begin
                    win_d   = sel_idx;
                    grnt_d  = N_CH'(1) << sel_idx;
                    addr_d  = addr_in[sel_idx*AW +: AW];
                    wdata_d = wdata_in[sel_idx*DW +: DW];
                    rw_d    = rd_wrt[sel_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                enable_d = 1'b1;
                cnt_d    = '0;
                if (flush_rd) begin
                    squash_d = 1'b1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_rd) begin
                    squash_d = 1'b1;
                end
                // done has priority over the terminal count
                if (done) begin
                    grnt_d   = '0;
                    rr_ptr_d = ptr_nxt;
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    grnt_d    = '0;
                    rr_ptr_d  = ptr_nxt;
                    squash_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            grnt_q    <= '0;
            enable_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            cnt_q     <= '0;
            squash_q  <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            grnt_q    <= grnt_d;
            enable_q  <= enable_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            cnt_q     <= cnt_d;
            squash_q  <= squash_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Completion is a same-cycle pass-through of done, masked for squashed reads.
    assign ch_done_c = (state_q == S_WAIT && done && !squash_q && !flush_rd) ? grnt_q : '0;

    assign ch_done    = ch_done_c;
    assign rdata      = (|ch_done_c) ? data_ca_out : '0;
    assign grnt       = grnt_q;
    assign enable     = enable_q;
    assign addr_ca    = addr_q;
    assign data_ca_in = wdata_q;
    assign rd_wrt_ca  = rw_q;
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (2-ch RR, 4-ch RR, 4-ch fixed).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic            clk = 1'b0;
    logic            rst, flsh, idle, done;
    logic [DW-1:0]   data_ca_out;
    logic [3:0]      req, rd_wrt;
    logic [4*AW-1:0] addr_in;
    logic [4*DW-1:0] wdata_in;

    logic [1:0]    r2_grnt, r2_ch_done;
    logic [DW-1:0] r2_rdata, r2_data;
    logic [AW-1:0] r2_addr;
    logic          r2_rw, r2_en, r2_tmo;

    logic [3:0]    r4_grnt, r4_ch_done;
    logic [DW-1:0] r4_rdata, r4_data;
    logic [AW-1:0] r4_addr;
    logic          r4_rw, r4_en, r4_tmo;

    logic [3:0]    f4_grnt, f4_ch_done;
    logic [DW-1:0] f4_rdata, f4_data;
    logic [AW-1:0] f4_addr;
    logic          f4_rw, f4_en, f4_tmo;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_g [5];

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_CH(2), .AW(AW), .DW(DW), .RR_EN(1), .TMO(8)) u_rr2 (
        .clk(clk), .rst(rst), .flsh(flsh), .req(req[1:0]), .rd_wrt(rd_wrt[1:0]),
        .addr_in(addr_in[2*AW-1:0]), .wdata_in(wdata_in[2*DW-1:0]),
        .grnt(r2_grnt), .ch_done(r2_ch_done), .rdata(r2_rdata), .addr_ca(r2_addr),
        .data_ca_in(r2_data), .rd_wrt_ca(r2_rw), .enable(r2_en), .idle(idle),
        .done(done), .data_ca_out(data_ca_out), .tmo_err(r2_tmo));

    mem_port_arbiter #(.N_CH(4), .AW(AW), .DW(DW), .RR_EN(1), .TMO(8)) u_rr4 (
        .clk(clk), .rst(rst), .flsh(flsh), .req(req), .rd_wrt(rd_wrt),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .grnt(r4_grnt), .ch_done(r4_ch_done), .rdata(r4_rdata), .addr_ca(r4_addr),
        .data_ca_in(r4_data), .rd_wrt_ca(r4_rw), .enable(r4_en), .idle(idle),
        .done(done), .data_ca_out(data_ca_out), .tmo_err(r4_tmo));

    mem_port_arbiter #(.N_CH(4), .AW(AW), .DW(DW), .RR_EN(0), .TMO(8)) u_fp4 (
        .clk(clk), .rst(rst), .flsh(flsh), .req(req), .rd_wrt(rd_wrt),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .grnt(f4_grnt), .ch_done(f4_ch_done), .rdata(f4_rdata), .addr_ca(f4_addr),
        .data_ca_in(f4_data), .rd_wrt_ca(f4_rw), .enable(f4_en), .idle(idle),
        .done(done), .data_ca_out(data_ca_out), .tmo_err(f4_tmo));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flsh = 1'b0; idle = 1'b1; done = 1'b0; data_ca_out = '0;
        req = '0; rd_wrt = '0; addr_in = '0; wdata_in = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (r2_grnt !== 2'b00) begin errors++; $display("FAIL rst_r2_grnt got=%b exp=00", r2_grnt); end
        checks++; if (r4_grnt !== 4'b0000) begin errors++; $display("FAIL rst_r4_grnt got=%b exp=0000", r4_grnt); end
        checks++; if (r4_en !== 1'b0 || r4_ch_done !== 4'b0000) begin errors++; $display("FAIL rst_r4_en_done got=%b/%b exp=0/0000", r4_en, r4_ch_done); end
        checks++; if (r4_tmo !== 1'b0 || r4_addr !== 16'h0000 || r4_rdata !== 16'h0000) begin errors++; $display("FAIL rst_r4_regs got tmo=%b addr=%h rdata=%h exp=0/0000/0000", r4_tmo, r4_addr, r4_rdata); end
    endtask

    task automatic test_single_read();
        addr_in[0 +: AW] = 16'h0010; rd_wrt = 4'b0000; req = 4'b0001;
        tick();
        checks++; if (r2_grnt !== 2'b01 || r2_en !== 1'b0) begin errors++; $display("FAIL t1_grant got grnt=%b en=%b exp=01/0", r2_grnt, r2_en); end
        req = 4'b0000;
        tick();
        checks++; if (r2_en !== 1'b1 || r2_addr !== 16'h0010 || r2_rw !== 1'b0) begin errors++; $display("FAIL t1_enable got en=%b addr=%h rw=%b exp=1/0010/0", r2_en, r2_addr, r2_rw); end
        tick();
        checks++; if (r2_en !== 1'b0) begin errors++; $display("FAIL t1_enable_pulse got=%b exp=0", r2_en); end
        tick();
        done = 1'b1; data_ca_out = 16'hBEEF;
        #1;
        checks++; if (r2_ch_done !== 2'b01 || r2_rdata !== 16'hBEEF) begin errors++; $display("FAIL t1_done got ch_done=%b rdata=%h exp=01/beef", r2_ch_done, r2_rdata); end
        tick();
        done = 1'b0;
        #1;
        checks++; if (r2_grnt !== 2'b00 || r2_ch_done !== 2'b00) begin errors++; $display("FAIL t1_release got grnt=%b ch_done=%b exp=00/00", r2_grnt, r2_ch_done); end
    endtask

    task automatic test_round_robin();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111; rd_wrt = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 10 && r4_grnt == 4'b0000; c++) tick();
            checks++; if (r4_grnt !== exp_g[i]) begin errors++; $display("FAIL t2_grant%0d got=%b exp=%b", i, r4_grnt, exp_g[i]); end
            tick(); tick();
            done = 1'b1; data_ca_out = 16'h0100 + 16'(i);
            #1;
            checks++; if (r4_ch_done !== exp_g[i]) begin errors++; $display("FAIL t2_done%0d got=%b exp=%b", i, r4_ch_done, exp_g[i]); end
            tick();
            done = 1'b0;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fixed_priority();
        req = 4'b1010; rd_wrt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 10 && f4_grnt == 4'b0000; c++) tick();
            checks++; if (f4_grnt !== 4'b0010) begin errors++; $display("FAIL t3_grant%0d got=%b exp=0010", i, f4_grnt); end
            tick(); tick();
            done = 1'b1;
            #1;
            checks++; if (f4_ch_done !== 4'b0010) begin errors++; $display("FAIL t3_done%0d got=%b exp=0010", i, f4_ch_done); end
            tick();
            done = 1'b0;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_grant_block();
        idle = 1'b0; req = 4'b0001; rd_wrt = 4'b0000;
        tick();
        checks++; if (r4_grnt !== 4'b0000) begin errors++; $display("FAIL blk_not_idle got=%b exp=0000", r4_grnt); end
        idle = 1'b1; flsh = 1'b1;
        tick();
        checks++; if (r4_grnt !== 4'b0000) begin errors++; $display("FAIL blk_flush got=%b exp=0000", r4_grnt); end
        flsh = 1'b0;
        tick();
        checks++; if (r4_grnt !== 4'b0001) begin errors++; $display("FAIL blk_resume got=%b exp=0001", r4_grnt); end
        req = 4'b0000;
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_flush_read();
        addr_in[AW +: AW] = 16'h0100; rd_wrt = 4'b0000; req = 4'b0010;
        for (int c = 0; c < 10 && r4_grnt == 4'b0000; c++) tick();
        checks++; if (r4_grnt !== 4'b0010) begin errors++; $display("FAIL t4_grant got=%b exp=0010", r4_grnt); end
        req = 4'b0000;
        tick();
        flsh = 1'b1;
        tick();
        flsh = 1'b0; done = 1'b1; data_ca_out = 16'h1234;
        #1;
        checks++; if (r4_ch_done !== 4'b0000 || r4_grnt !== 4'b0010) begin errors++; $display("FAIL t4_squash got ch_done=%b grnt=%b exp=0000/0010", r4_ch_done, r4_grnt); end
        tick();
        done = 1'b0;
        #1;
        checks++; if (r4_grnt !== 4'b0000 || r4_tmo !== 1'b0) begin errors++; $display("FAIL t4_clear got grnt=%b tmo=%b exp=0000/0", r4_grnt, r4_tmo); end
        req = 4'b0010;
        for (int c = 0; c < 10 && r4_grnt == 4'b0000; c++) tick();
        req = 4'b0000;
        tick(); tick();
        done = 1'b1; data_ca_out = 16'h5678;
        #1;
        checks++; if (r4_ch_done !== 4'b0010 || r4_rdata !== 16'h5678) begin errors++; $display("FAIL t4_next got ch_done=%b rdata=%h exp=0010/5678", r4_ch_done, r4_rdata); end
        tick();
        done = 1'b0;
    endtask

    task automatic test_timeout();
        addr_in[0 +: AW] = 16'h0042; wdata_in[0 +: DW] = 16'hA5A5; rd_wrt = 4'b0001; req = 4'b0001;
        for (int c = 0; c < 10 && r4_grnt == 4'b0000; c++) tick();
        req = 4'b0000;
        tick();
        checks++; if (r4_en !== 1'b1 || r4_addr !== 16'h0042 || r4_data !== 16'hA5A5 || r4_rw !== 1'b1) begin errors++; $display("FAIL t5_issue got en=%b addr=%h data=%h rw=%b exp=1/0042/a5a5/1", r4_en, r4_addr, r4_data, r4_rw); end
        for (int i = 1; i < 8; i++) tick();
        checks++; if (r4_tmo !== 1'b0 || r4_grnt !== 4'b0001) begin errors++; $display("FAIL t5_before got tmo=%b grnt=%b exp=0/0001", r4_tmo, r4_grnt); end
        tick();
        checks++; if (r4_tmo !== 1'b1 || r4_grnt !== 4'b0000 || r4_ch_done !== 4'b0000) begin errors++; $display("FAIL t5_expire got tmo=%b grnt=%b ch_done=%b exp=1/0000/0000", r4_tmo, r4_grnt, r4_ch_done); end
        repeat (3) tick();
        checks++; if (r4_tmo !== 1'b1) begin errors++; $display("FAIL t5_sticky got=%b exp=1", r4_tmo); end
    endtask

    task automatic test_async_reset();
        rd_wrt = 4'b0000; req = 4'b0100;
        for (int c = 0; c < 10 && r4_grnt == 4'b0000; c++) tick();
        checks++; if (r4_grnt !== 4'b0100) begin errors++; $display("FAIL t6_grant got=%b exp=0100", r4_grnt); end
        req = 4'b0000;
        tick();
        #2;
        done = 1'b1;
        #1;
        checks++; if (r4_ch_done !== 4'b0100 || r4_en !== 1'b1) begin errors++; $display("FAIL t6_pre got ch_done=%b en=%b exp=0100/1", r4_ch_done, r4_en); end
        rst = 1'b1;
        #1;
        checks++; if (r4_grnt !== 4'b0000 || r4_en !== 1'b0 || r4_ch_done !== 4'b0000 || r4_tmo !== 1'b0) begin errors++; $display("FAIL t6_async got grnt=%b en=%b ch_done=%b tmo=%b exp=0000/0/0000/0", r4_grnt, r4_en, r4_ch_done, r4_tmo); end
        done = 1'b0;
        tick();
        rst = 1'b0; req = 4'b1111;
        tick();
        checks++; if (r4_grnt !== 4'b0001) begin errors++; $display("FAIL t6_after got=%b exp=0001", r4_grnt); end
        req = 4'b0000;
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset();
        test_round_robin();
        test_reset();
        test_fixed_priority();
        test_reset();
        test_grant_block();
        test_reset();
        test_flush_read();
        test_reset();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
